// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the round-robin memory bus: the controller state
// enum and the encoding of the per-core request-type bit.
// ---------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      READ_DLV = 2'd2
   } state_e;

   localparam logic WE_WRITE = 1'b1;
   localparam logic WE_READ  = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search. Returns the first requesting core found
// when scanning upward from last_i+1 (wrapping modulo NUM_CORES).
//   req_i  : per-core request vector
//   last_i : index of the most recently served core
//   win_o  : index of the selected core (0 when any_o is low)
//   any_o  : high when at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req_i,
   input  logic [IDX_W-1:0]     last_i,
   output logic [IDX_W-1:0]     win_o,
   output logic                 any_o
);

   logic [IDX_W-1:0] idx;

   // Scan from the farthest candidate down to last+1 so the nearest
   // requester after the previous winner is the one left in win_o.
   always_comb begin
      win_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         idx = IDX_W'((int'(last_i) + k) % NUM_CORES);
         if (req_i[idx]) begin
            win_o = idx;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mem_bus.sv
// ---------------------------------------------------------------------------
// rr_mem_bus
// Serialises accesses from NUM_CORES requesters onto one single-port
// synchronous RAM with fair round-robin arbitration.
//   clk, reset : clock, synchronous active-high reset
//   req/we     : per-core request and type (1 = write, 0 = read)
//   addr/wdata : packed per-core address / write data (core i at slice i)
//   grant      : one-hot, 1-cycle pulse when a core's request is accepted
//   rvalid     : one-hot, 1-cycle pulse while rdata holds that core's read
//   rdata      : shared read-return data, holds between returns
//   ram_*      : RAM address, write data, write enable; ram_rdata returns
//                the word one cycle after the address edge
// All outputs are registered.
// ---------------------------------------------------------------------------
module rr_mem_bus
   import bus_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 9
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          we,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   wdata,
   output logic [NUM_CORES-1:0]          grant,
   output logic [NUM_CORES-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_wdata,
   output logic                          ram_we,
   input  logic [DATA_W-1:0]             ram_rdata
);

   localparam int IDX_W = $clog2(NUM_CORES);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic                  wr_q, wr_d;
   logic [NUM_CORES-1:0]  grant_q, grant_d;
   logic [NUM_CORES-1:0]  rvalid_q, rvalid_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
   logic                  ram_we_q, ram_we_d;

   logic [IDX_W-1:0]      arb_win;
   logic                  arb_any;

   rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_arb (
      .req_i  (req),
      .last_i (last_q),
      .win_o  (arb_win),
      .any_o  (arb_any)
   );

   // last_q doubles as the index of the core whose access is in flight:
   // it is updated at grant and only a reset (which abandons the access)
   // can change it before the read data is returned.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      wr_d        = wr_q;
      grant_d     = '0;
      rvalid_d    = '0;
      rdata_d     = rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               last_d      = arb_win;
               wr_d        = we[arb_win];
               grant_d     = NUM_CORES'(1) << arb_win;
               ram_addr_d  = addr[arb_win*ADDR_W +: ADDR_W];
               ram_wdata_d = wdata[arb_win*DATA_W +: DATA_W];
               ram_we_d    = we[arb_win];
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            state_d = (wr_q == WE_WRITE) ? IDLE : READ_DLV;
         end
         READ_DLV: begin
            rdata_d  = ram_rdata;
            rvalid_d = NUM_CORES'(1) << last_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= IDX_W'(NUM_CORES - 1);
         wr_q        <= WE_READ;
         grant_q     <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         wr_q        <= wr_d;
         grant_q     <= grant_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
      end
   end

   assign grant     = grant_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_rr_mem_bus.sv
// ---------------------------------------------------------------------------
// tb_rr_mem_bus
// Main instance: 4 cores, 8-bit data, 9-bit address, checked every cycle
// against a transaction-level model. Second instance: 3 cores, 16/12 bits,
// directed checks only.
// ---------------------------------------------------------------------------
module tb_rr_mem_bus;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 9;
   localparam int SN  = 3;
   localparam int SDW = 16;
   localparam int SAW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic            reset;
   logic [N-1:0]    req, we, grant, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
   logic [AW-1:0]   ram_addr;
   logic            ram_we;

   rr_mem_bus #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) u_dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata));

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- sweep DUT ----------------
   logic              s_reset;
   logic [SN-1:0]     s_req, s_we, s_grant, s_rvalid;
   logic [SN*SAW-1:0] s_addr;
   logic [SN*SDW-1:0] s_wdata;
   logic [SDW-1:0]    s_rdata, s_ram_wdata, s_ram_rdata;
   logic [SAW-1:0]    s_ram_addr;
   logic              s_ram_we;

   rr_mem_bus #(.NUM_CORES(SN), .DATA_W(SDW), .ADDR_W(SAW)) u_swp (
      .clk(clk), .reset(s_reset), .req(s_req), .we(s_we), .addr(s_addr),
      .wdata(s_wdata), .grant(s_grant), .rvalid(s_rvalid), .rdata(s_rdata),
      .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we),
      .ram_rdata(s_ram_rdata));

   logic [SDW-1:0] s_mem [0:(1<<SAW)-1];
   always @(posedge clk) begin
      if (s_ram_we) s_mem[s_ram_addr] <= s_ram_wdata;
      s_ram_rdata <= s_mem[s_ram_addr];
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: each accepted request occupies the bus for
   // 2 cycles (write) or 3 cycles (read); a read returns 2 edges after
   // its sampling edge with the memory contents seen at acceptance.
   bit            m_ok = 1'b0;
   int            cyc  = 0;
   int            m_last, m_free, m_due, m_pcore, m_w;
   bit            m_pend;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   logic [N-1:0]  e_grant, e_rvalid;
   logic [DW-1:0] e_rdata, e_wdata;
   logic [AW-1:0] e_addr;
   logic          e_we;
   int            glog[$];

   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_ok = 1'b1;
         e_grant = '0; e_rvalid = '0; e_rdata = '0; e_wdata = '0;
         e_addr = '0; e_we = 1'b0;
         m_last = N - 1; m_free = cyc + 1; m_pend = 1'b0;
      end else if (m_ok) begin
         e_grant = '0; e_rvalid = '0; e_we = 1'b0;
         if (m_pend && cyc == m_due) begin
            e_rvalid[m_pcore] = 1'b1;
            e_rdata = m_pdata;
            m_pend = 1'b0;
         end
         if (cyc >= m_free && req != '0) begin
            m_w = -1;
            for (int k = 1; k <= N; k++)
               if (m_w < 0 && req[(m_last + k) % N]) m_w = (m_last + k) % N;
            e_grant[m_w] = 1'b1;
            e_addr  = addr[m_w*AW +: AW];
            e_wdata = wdata[m_w*DW +: DW];
            e_we    = we[m_w];
            m_last  = m_w;
            if (we[m_w]) begin
               m_mem[e_addr] = e_wdata;
               m_free = cyc + 2;
            end else begin
               m_pend = 1'b1; m_due = cyc + 2; m_pcore = m_w;
               m_pdata = m_mem[e_addr];
               m_free = cyc + 3;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("grant", grant, e_grant);
         chk("rvalid", rvalid, e_rvalid);
         chk("rdata", rdata, e_rdata);
         chk("ram_we", ram_we, e_we);
         chk("ram_addr", ram_addr, e_addr);
         chk("ram_wdata", ram_wdata, e_wdata);
         for (int i = 0; i < N; i++)
            if (grant[i]) glog.push_back(i);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      we[i]  = w;
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  rd0_cnt;
      logic [DW-1:0] rd0_data;
      bit  ok, g3;

      reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      s_reset = 1'b1; s_req = '0; s_we = '0; s_addr = '0; s_wdata = '0;
      for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; m_mem[i] = '0; end
      for (int i = 0; i < (1<<SAW); i++) s_mem[i] = '0;
      mem[9'h010]   = 8'h3C;
      m_mem[9'h010] = 8'h3C;

      repeat (2) tick();
      reset = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_ram_we", ram_we, 0);

      // core0 write 0xA5 -> 0x1F3
      set_req(0, 1'b1, 9'h1F3, 8'hA5);
      tick();
      chk("wr_grant", grant, 4'b0001);
      chk("wr_ram_we", ram_we, 1);
      chk("wr_ram_addr", ram_addr, 9'h1F3);
      chk("wr_ram_wdata", ram_wdata, 8'hA5);
      req[0] = 1'b0;
      tick();
      chk("wr_grant_clr", grant, 0);
      chk("wr_we_clr", ram_we, 0);

      // core1 read 0x010 -> 0x3C, two edges after sampling
      set_req(1, 1'b0, 9'h010, 8'h00);
      tick();
      chk("rd_grant", grant, 4'b0010);
      req[1] = 1'b0;
      tick();
      chk("rd_rvalid_early", rvalid, 0);
      tick();
      chk("rd_rvalid", rvalid, 4'b0010);
      chk("rd_rdata", rdata, 8'h3C);
      tick();
      chk("rd_rvalid_clr", rvalid, 0);
      chk("rd_rdata_hold", rdata, 8'h3C);

      // round robin with all four cores holding requests
      reset = 1'b1;
      glog.delete();
      tick();
      reset = 1'b0;
      set_req(0, 1'b1, 9'h100, 8'h11);
      set_req(1, 1'b0, 9'h100, 8'h00);
      set_req(2, 1'b1, 9'h102, 8'h22);
      set_req(3, 1'b0, 9'h102, 8'h00);
      repeat (26) tick();
      req = '0;
      repeat (4) tick();
      chk("rr_count", (glog.size() >= 8), 1);
      for (int j = 0; j < 8 && j < glog.size(); j++)
         chk("rr_order", glog[j], j % 4);
      for (int j = 0; j + 3 < glog.size(); j++) begin
         ok = 1'b1;
         for (int a = j; a < j + 4; a++)
            for (int b = a + 1; b < j + 4; b++)
               if (glog[a] == glog[b]) ok = 1'b0;
         chk("rr_window", ok, 1);
      end

      // simultaneous core0 read / core1 write right after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      glog.delete();
      rd0_cnt = 0; rd0_data = '0;
      set_req(0, 1'b0, 9'h010, 8'h00);
      set_req(1, 1'b1, 9'h055, 8'h77);
      for (int t = 0; t < 12; t++) begin
         tick();
         for (int i = 0; i < 2; i++) if (grant[i]) req[i] = 1'b0;
         if (rvalid[0]) begin rd0_cnt++; rd0_data = rdata; end
      end
      chk("sim_grants", glog.size(), 2);
      if (glog.size() >= 2) begin
         chk("sim_first", glog[0], 0);
         chk("sim_second", glog[1], 1);
      end
      chk("sim_rd0_cnt", rd0_cnt, 1);
      chk("sim_rd0_data", rd0_data, 8'h3C);
      set_req(3, 1'b0, 9'h055, 8'h00);
      tick();
      chk("sim_rb_grant", grant, 4'b1000);
      req[3] = 1'b0;
      repeat (2) tick();
      chk("sim_rb_rvalid", rvalid, 4'b1000);
      chk("sim_rb_rdata", rdata, 8'h77);
      tick();

      // reset during ACCESS of a read
      set_req(2, 1'b0, 9'h010, 8'h00);
      tick();
      chk("mid_grant", grant, 4'b0100);
      req[2] = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int t = 0; t < 4; t++) begin
         chk("mid_no_rvalid", rvalid, 0);
         chk("mid_no_we", ram_we, 0);
         tick();
      end
      set_req(3, 1'b1, 9'h020, 8'h5A);
      set_req(0, 1'b1, 9'h021, 8'h6B);
      tick();
      chk("mid_next_grant", grant, 4'b0001);
      req[0] = 1'b0;
      g3 = 1'b0;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (grant[3]) begin g3 = 1'b1; req[3] = 1'b0; end
      end
      chk("mid_core3_served", g3, 1);

      // parameter sweep instance
      s_reset = 1'b0;
      tick();
      s_req[2] = 1'b1; s_we[2] = 1'b1;
      s_addr[2*SAW +: SAW] = 12'hABC; s_wdata[2*SDW +: SDW] = 16'hBEEF;
      tick();
      chk("swp_wr_grant", s_grant, 3'b100);
      chk("swp_ram_we", s_ram_we, 1);
      chk("swp_ram_addr", s_ram_addr, 12'hABC);
      chk("swp_ram_wdata", s_ram_wdata, 16'hBEEF);
      s_req = '0;
      tick();
      s_req[2] = 1'b1; s_we[2] = 1'b0;
      tick();
      chk("swp_rd_grant", s_grant, 3'b100);
      s_req = '0;
      tick();
      chk("swp_rvalid_early", s_rvalid, 0);
      tick();
      chk("swp_rvalid", s_rvalid, 3'b100);
      chk("swp_rdata", s_rdata, 16'hBEEF);
      tick();
      chk("swp_rvalid_clr", s_rvalid, 0);
      // last served was core2: the search wraps to core0 before core1
      s_req[0] = 1'b1; s_req[1] = 1'b1; s_we = '0;
      tick();
      chk("swp_wrap_grant", s_grant, 3'b001);
      s_req = '0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mem_bus.md
# rr_mem_bus

Parametrised round-robin bus between `NUM_CORES` requesters and one single-port synchronous RAM. It generalises the two-core shared bus to N cores, configurable data and address widths, and a per-core read-return handshake. Arbitration is fair round-robin. The block sits between the core array and the shared RAM and serialises all accesses.

## Interface
- `NUM_CORES`, default 2: number of requesters; must be ≥2.
- `DATA_W`, default 8: data width.
- `ADDR_W`, default 9: RAM address width.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_CORES: per-core access request.
- `we` in NUM_CORES: per-core request type; 1 = write, 0 = read.
- `addr` in NUM_CORES*ADDR_W: core i uses `[i*ADDR_W +: ADDR_W]`.
- `wdata` in NUM_CORES*DATA_W: core i uses `[i*DATA_W +: DATA_W]`.
- `grant` out NUM_CORES: one-hot; high for 1 cycle when core i's request is accepted.
- `rvalid` out NUM_CORES: one-hot; high for 1 cycle when `rdata` holds core i's read result.
- `rdata` out DATA_W: shared read-return data.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after the address edge.

## Operation
- States: IDLE, ACCESS, READ_DLV.
- **IDLE:**
  - If any `req` is high, select the winner `w` as the first core with `req` high, searching from `last+1` modulo NUM_CORES.
  - Latch `w`, `we[w]`, `addr[w]` and `wdata[w]`.
  - Register `grant[w]`=1, `ram_addr`, `ram_wdata`, and `ram_we`=`we[w]`.
  - Set `last`←`w` and go to ACCESS.
  - If no `req` is high, stay in IDLE with all strobes 0.
- **ACCESS:**
  - Clear `grant` and `ram_we`.
  - For a write, go to IDLE.
  - For a read, go to READ_DLV.
- **READ_DLV:**
  - Register `rdata`←`ram_rdata` and `rvalid[w]`=1.
  - Go to IDLE.
  - `rvalid` clears on the next edge.
- **Requester rule:** hold `req`, `we`, `addr` and `wdata` stable until `grant[i]` is seen high, then deassert `req` on that edge or present a new request. A new request is sampled no earlier than the next IDLE cycle.
- **Fairness:** a core that was just served has the lowest priority in the next arbitration. No starvation: any held request is served within NUM_CORES accesses.
- **`rdata` hold:** `rdata` holds its last value when `rvalid` is 0.
- **Reset:**
  - All outputs go to 0, including `rdata` and `ram_addr`.
  - State goes to IDLE.
  - `last`←NUM_CORES-1, so core 0 has first priority.
- **Reset mid-operation:** the access is abandoned. `ram_we` is 0 and no `rvalid` is issued for the abandoned read.

## Timing
- Request sampled at edge E0; `grant` and RAM signals are valid in cycle E0→E1; the RAM write or read-address capture happens at E1.
- Write: 2 cycles from sampling edge to return to IDLE. Back-to-back writes give 1 access per 2 cycles.
- Read:
  - `rvalid`/`rdata` are valid in cycle E2→E3.
  - Latency is 2 edges from sampling to `rvalid` assertion.
  - Throughput is 1 access per 3 cycles.
- `req` arriving while not in IDLE waits; it is never dropped.
- All outputs are registered.

## Structure
- Package `bus_pkg`: the state enum (IDLE, ACCESS, READ_DLV) and the `WE_WRITE`/`WE_READ` constants.
- Index width is `$clog2(NUM_CORES)`.
- Sub-module `rr_arbiter`: combinational round-robin search taking `req` and `last`, producing the winner index and an `any` flag. It is instantiated once.

## Test plan
- **Reset values:** after reset, all outputs are 0. Then core0 writes 0xA5 to address 0x1F3 → `grant[0]` for 1 cycle; `ram_we`=1, `ram_addr`=0x1F3, `ram_wdata`=0xA5 in the same cycle.
- **Read latency:** core1 reads address 0x010 with RAM holding 0x3C → `rvalid[1]`=1 and `rdata`=0x3C exactly 2 edges after the sampling edge; `rvalid[0]` stays 0.
- **Round-robin order:** with NUM_CORES=4, all four cores hold `req` continuously → grant order is 0,1,2,3,0,…; no core is granted twice within any 4 consecutive grants.
- **Simultaneous requests:** core0 and core1 request in the same cycle right after reset → core0 is served first and core1 next; core1's `req` held through core0's read is neither lost nor duplicated.
- **Reset mid-read:** assert `reset` in ACCESS of a read → no `rvalid` is issued, `ram_we`=0, and the next request after reset is granted to core0.
- **Parameter sweep:** DATA_W=16, ADDR_W=12, NUM_CORES=3 → writing 0xBEEF to 0xABC and reading it back returns 0xBEEF on `rdata` with the correct `rvalid` bit.
